// File: rtl/regfile32x32_pkg.sv
// regfile32x32_pkg: shared register-file constants and the scoreboard popcount helper
package regfile32x32_pkg;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam int NUM_REGS = 32;
   localparam int REG_AW = 5;
   function automatic logic [5:0] popcount(input logic [NUM_REGS-2:0] v);
      logic [5:0] c;
      c = '0;
      for (int k = 0; k < NUM_REGS - 1; k++) c = c + 6'(v[k]);
      return c;
   endfunction
endpackage

// File: rtl/mux32x32.sv
// mux32x32: 32-way combinational word selector
module mux32x32
   import regfile32x32_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [REG_AW-1:0] sel_i,
   input  logic [WIDTH-1:0]  data_i [NUM_REGS],
   output logic [WIDTH-1:0]  data_o
);
   assign data_o = data_i[sel_i];
endmodule

// File: rtl/regfile32x32.sv
// regfile32x32: 32x32 register file with writeback bypass and pending-write scoreboard
module regfile32x32
   import regfile32x32_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit BYPASS = 1'b1
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic [REG_AW-1:0] rna,
   input  logic [REG_AW-1:0] rnb,
   output logic [WIDTH-1:0]  qa,
   output logic [WIDTH-1:0]  qb,
   input  logic              we,
   input  logic [REG_AW-1:0] wn,
   input  logic [WIDTH-1:0]  d,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   output logic              busy_a,
   output logic              busy_b,
   output logic [5:0]        pend_cnt
);
   logic [WIDTH-1:0]    regs_q [1:NUM_REGS-1];
   logic [WIDTH-1:0]    rd_data [NUM_REGS];
   logic [NUM_REGS-1:1] pend_q, pend_d;
   logic [NUM_REGS-1:0] pend_vec;
   logic [5:0]          cnt_q, cnt_d;
   logic [WIDTH-1:0]    mux_a, mux_b;
   logic                wr_en, byp_a, byp_b;

   assign wr_en = we && wn != REG_ZERO;
   assign rd_data[0] = '0;
   for (genvar i = 1; i < NUM_REGS; i++) begin : g_rd
      assign rd_data[i] = regs_q[i];
   end

   // Storage: register 0 is not stored; writes to it fall out of wr_en
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int r = 1; r < NUM_REGS; r++) regs_q[r] <= '0;
      end else begin
         for (int r = 1; r < NUM_REGS; r++) if (wr_en && wn == REG_AW'(r)) regs_q[r] <= d;
      end
   end

   // Scoreboard next state: a new issue supersedes a same-cycle writeback
   always_comb begin
      pend_d = pend_q;
      for (int r = 1; r < NUM_REGS; r++)
         pend_d[r] = (iss_valid && iss_rd == REG_AW'(r)) ? 1'b1 :
                     (wr_en && wn == REG_AW'(r)) ? 1'b0 : pend_q[r];
      cnt_d = popcount(pend_d);
   end

   // Scoreboard and its count update on the same edge
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   mux32x32 #(.WIDTH(WIDTH)) u_mux_a (.sel_i(rna), .data_i(rd_data), .data_o(mux_a));
   mux32x32 #(.WIDTH(WIDTH)) u_mux_b (.sel_i(rnb), .data_i(rd_data), .data_o(mux_b));

   assign byp_a    = BYPASS && wr_en && wn == rna;
   assign byp_b    = BYPASS && wr_en && wn == rnb;
   assign qa       = byp_a ? d : mux_a;
   assign qb       = byp_b ? d : mux_b;
   assign pend_vec = {pend_q, 1'b0};
   assign busy_a   = pend_vec[rna] && !byp_a;
   assign busy_b   = pend_vec[rnb] && !byp_b;
   assign pend_cnt = cnt_q;
endmodule
